// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared types and constants for the pipeline-stage registers.
//   if_id_t      : payload carried from fetch to decode (pc, instr, fault)
//   NOP_INSTR    : bubble encoding presented when no entry is valid
//   skid_state_e : occupancy of a 2-entry skid buffer
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int IF_ID_PC_W    = 64;
  localparam int IF_ID_INSTR_W = 32;

  // addi x0, x0, 0
  localparam logic [IF_ID_INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [IF_ID_PC_W-1:0]    pc;
    logic [IF_ID_INSTR_W-1:0] instr;
    logic                     fault;
  } if_id_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // nothing held
    ONE   = 2'd1,  // main slot only
    FULL  = 2'd2   // main + skid slot
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// ---------------------------------------------------------------------------
// pipe_skid_buf
// Generic 2-entry valid/ready skid buffer with flush. The main slot drives
// the output; the skid slot absorbs the one entry that can arrive in the
// cycle the consumer stalls. in_ready_o and out_valid_o come straight from
// flops, so neither side sees a combinational path from the other.
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   flush_i          drop every held entry and any entry offered this cycle
//   in_valid_i/in_ready_o/in_data_i     upstream handshake and payload
//   out_valid_o/out_ready_i/out_data_o  downstream handshake and payload
// ---------------------------------------------------------------------------
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic flush_i,
  input  logic in_valid_i,
  output logic in_ready_o,
  input  T     in_data_i,
  output logic out_valid_o,
  input  logic out_ready_i,
  output T     out_data_o
);

  skid_state_e state_q;
  T            main_q;
  T            skid_q;
  logic        in_ready_q;
  logic        out_valid_q;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid_i & in_ready_q;
  assign out_fire = out_valid_q & out_ready_i;

  // NOTE: all state here uses <= so every branch reads the pre-edge values;
  // a blocking assignment would let main_q<=skid_q see a half-updated skid.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= EMPTY;
      // NOTE: the payload slots are reset too because pc_out must read 0
      // after reset; otherwise data-only storage would not need a reset.
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (flush_i) begin
      // main_q keeps its contents so the bubble still shows the last pc.
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_q      <= in_data_i;
            state_q     <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_q <= in_data_i;
          end else if (out_fire) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
          end else if (in_fire) begin
            // Consumer stalled while producer still sent: park in skid.
            skid_q     <= in_data_i;
            state_q    <= FULL;
            in_ready_q <= 1'b0;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_q     <= skid_q;
            state_q    <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = main_q;

endmodule

// File: rtl/if_id_skid_reg.sv
// ---------------------------------------------------------------------------
// if_id_skid_reg
// IF/ID pipeline register: a 2-entry skid buffer carrying {pc, instr, fault}
// from fetch to decode, plus bubble muxing so decode sees a NOP and no fault
// whenever nothing valid is presented.
// Ports:
//   clk, reset (sync, active-high), flush
//   in_valid, in_ready, pc_in, instruction_in, fault_in      from fetch
//   out_valid, out_ready, pc_out, instruction_out, fault_out to decode
// ---------------------------------------------------------------------------
module if_id_skid_reg #(
  parameter int                     DATA_WIDTH  = pipe_pkg::IF_ID_PC_W,
  parameter int                     INSTR_WIDTH = pipe_pkg::IF_ID_INSTR_W,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = pipe_pkg::NOP_INSTR
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  pc_in,
  input  logic [INSTR_WIDTH-1:0] instruction_in,
  input  logic                   fault_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  pc_out,
  output logic [INSTR_WIDTH-1:0] instruction_out,
  output logic                   fault_out
);

  // Same layout as pipe_pkg::if_id_t, but sized by this instance's widths.
  typedef struct packed {
    logic [DATA_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
    logic                   fault;
  } entry_t;

  entry_t in_entry;
  entry_t out_entry;

  assign in_entry = '{pc: pc_in, instr: instruction_in, fault: fault_in};

  pipe_skid_buf #(
    .T (entry_t)
  ) u_skid (
    .clk_i       (clk),
    .reset_i     (reset),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_entry),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_entry)
  );

  // Bubble: pc keeps its last value, instruction and fault are neutralised.
  assign pc_out          = out_entry.pc;
  assign instruction_out = out_valid ? out_entry.instr : NOP_INSTR;
  assign fault_out       = out_valid & out_entry.fault;

endmodule

// File: tb/tb_if_id_skid_reg.sv
module tb_if_id_skid_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] pc_in;
  logic [31:0] instruction_in;
  logic        fault_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] pc_out;
  logic [31:0] instruction_out;
  logic        fault_out;

  if_id_skid_reg dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .pc_in           (pc_in),
    .instruction_in  (instruction_in),
    .fault_in        (fault_in),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
    .fault_out       (fault_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  // One table row: inputs for a cycle and the outputs expected after the edge.
  typedef struct {
    logic        rst;
    logic        iv;
    logic [63:0] pc;
    logic        flt;
    logic        ordy;
    logic        fl;
    logic        e_ir;
    logic        e_ov;
    logic [63:0] e_pc;
    logic        e_flt;
  } vec_t;

  ent_t        sb[$];
  logic [63:0] last_pc;
  int          errors;
  int          checks;

  function automatic logic [31:0] mk_instr(input logic [63:0] pc);
    return {pc[29:0], 2'b11} ^ 32'h1234_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare DUT outputs against the scoreboard front (or the bubble).
  task automatic check_outputs();
    check("in_ready", {63'd0, in_ready}, {63'd0, sb.size() < 2});
    check("out_valid", {63'd0, out_valid}, {63'd0, sb.size() != 0});
    if (sb.size() != 0) begin
      check("pc_out", pc_out, sb[0].pc);
      check("instruction_out", {32'd0, instruction_out}, {32'd0, sb[0].instr});
      check("fault_out", {63'd0, fault_out}, {63'd0, sb[0].fault});
      last_pc = sb[0].pc;
    end else begin
      check("bubble_pc", pc_out, last_pc);
      check("bubble_instr", {32'd0, instruction_out}, {32'd0, NOP});
      check("bubble_fault", {63'd0, fault_out}, 64'd0);
    end
  endtask

  // Drive one cycle from the negedge, update the model, check at next negedge.
  task automatic cycle(input logic rst, input logic iv, input logic [63:0] pc,
                       input logic flt, input logic ordy, input logic fl);
    logic m_ir, m_ov, in_fire, out_fire;
    ent_t e;
    reset          = rst;
    in_valid       = iv;
    pc_in          = pc;
    instruction_in = mk_instr(pc);
    fault_in       = flt;
    out_ready      = ordy;
    flush          = fl;
    m_ir     = (sb.size() < 2);
    m_ov     = (sb.size() != 0);
    in_fire  = iv & m_ir;
    out_fire = m_ov & ordy;
    if (rst) begin
      sb.delete();
      last_pc = 64'd0;
    end else begin
      if (out_fire) void'(sb.pop_front());
      if (fl) sb.delete();
      else if (in_fire) begin
        e = '{pc: pc, instr: mk_instr(pc), fault: flt};
        sb.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  vec_t vecs[$];

  task automatic add(input logic rst, input logic iv, input logic [63:0] pc, input logic flt,
                     input logic ordy, input logic fl, input logic e_ir, input logic e_ov,
                     input logic [63:0] e_pc, input logic e_flt);
    vec_t v;
    v = '{rst: rst, iv: iv, pc: pc, flt: flt, ordy: ordy, fl: fl,
          e_ir: e_ir, e_ov: e_ov, e_pc: e_pc, e_flt: e_flt};
    vecs.push_back(v);
  endtask

  initial begin
    logic [63:0] rpc;
    logic        iv, ordy, fl, flt;
    errors   = 0;
    checks   = 0;
    last_pc  = 64'd0;
    reset    = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    pc_in    = 64'd0;
    instruction_in = 32'd0;
    fault_in = 1'b0;
    out_ready = 1'b0;

    //   rst iv  pc        flt ordy fl   ir  ov  pc_out    flt
    // Stream: one entry per cycle, in_ready never drops.
    add(0, 1, 64'h1000, 0, 1, 0,  1, 1, 64'h1000, 0);
    add(0, 1, 64'h1004, 0, 1, 0,  1, 1, 64'h1004, 0);
    add(0, 1, 64'h1008, 0, 1, 0,  1, 1, 64'h1008, 0);
    add(0, 0, 64'h0,    0, 1, 0,  1, 0, 64'h1008, 0);
    // Stall: 0x2004 goes to skid, 0x2008 held upstream, 0x2000 held at out.
    add(0, 1, 64'h2000, 0, 1, 0,  1, 1, 64'h2000, 0);
    add(0, 1, 64'h2004, 0, 0, 0,  0, 1, 64'h2000, 0);
    add(0, 1, 64'h2008, 0, 0, 0,  0, 1, 64'h2000, 0);
    add(0, 1, 64'h2008, 0, 0, 0,  0, 1, 64'h2000, 0);
    add(0, 1, 64'h2008, 0, 1, 0,  1, 1, 64'h2004, 0);
    add(0, 1, 64'h2008, 0, 1, 0,  1, 1, 64'h2008, 0);
    add(0, 0, 64'h0,    0, 1, 0,  1, 0, 64'h2008, 0);
    // Fault flag only while its entry is valid.
    add(0, 1, 64'h5000, 1, 1, 0,  1, 1, 64'h5000, 1);
    add(0, 0, 64'h0,    0, 1, 0,  1, 0, 64'h5000, 0);
    // Flush in FULL with 0x3008 offered.
    add(0, 1, 64'h3000, 0, 0, 0,  1, 1, 64'h3000, 0);
    add(0, 1, 64'h3004, 0, 0, 0,  0, 1, 64'h3000, 0);
    add(0, 1, 64'h3008, 0, 0, 1,  1, 0, 64'h3000, 0);
    add(0, 0, 64'h0,    0, 1, 0,  1, 0, 64'h3000, 0);
    // Flush in ONE discards the entry accepted that same cycle.
    add(0, 1, 64'h3100, 0, 0, 0,  1, 1, 64'h3100, 0);
    add(0, 1, 64'h3104, 0, 0, 1,  1, 0, 64'h3100, 0);
    add(0, 0, 64'h0,    0, 1, 0,  1, 0, 64'h3100, 0);

    // Reset state.
    cycle(1, 0, 64'h0, 0, 0, 0);
    cycle(1, 0, 64'h0, 0, 0, 0);
    check("reset_pc", pc_out, 64'd0);
    check("reset_instr", {32'd0, instruction_out}, {32'd0, NOP});
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);

    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].iv, vecs[i].pc, vecs[i].flt, vecs[i].ordy, vecs[i].fl);
      check($sformatf("row%0d_in_ready", i), {63'd0, in_ready}, {63'd0, vecs[i].e_ir});
      check($sformatf("row%0d_out_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].e_ov});
      check($sformatf("row%0d_pc_out", i), pc_out, vecs[i].e_pc);
      check($sformatf("row%0d_fault_out", i), {63'd0, fault_out}, {63'd0, vecs[i].e_flt});
    end

    // Reset mid-FULL: both entries dropped, then 0x4000 emerges after one cycle.
    cycle(0, 1, 64'h4100, 0, 0, 0);
    cycle(0, 1, 64'h4104, 0, 0, 0);
    check("midfull_in_ready", {63'd0, in_ready}, 64'd0);
    cycle(1, 1, 64'h4108, 1, 1, 0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_pc_out", pc_out, 64'd0);
    check("rst_instr", {32'd0, instruction_out}, {32'd0, NOP});
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    cycle(0, 1, 64'h4000, 0, 1, 0);
    check("post_rst_valid", {63'd0, out_valid}, 64'd1);
    check("post_rst_pc", pc_out, 64'h4000);
    cycle(0, 0, 64'h0, 0, 1, 0);

    // Random valid/ready with periodic flush against the scoreboard.
    rpc = 64'h8000;
    for (int i = 0; i < 1500; i++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ((i % 37) == 36);
      flt  = ($urandom_range(0, 7) == 0);
      cycle(0, iv, rpc, flt, ordy, fl);
      // Producer advances only once its entry has been accepted.
      if (iv && in_ready_was_high(i)) rpc = rpc + 64'd4;
    end

    // Drain.
    for (int i = 0; i < 3; i++) cycle(0, 0, 64'h0, 0, 1, 0);
    check("drained_valid", {63'd0, out_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Tracks the in_ready value seen by the previous random cycle's driver.
  logic ir_hist;
  always @(posedge clk) ir_hist <= in_ready;

  function automatic logic in_ready_was_high(input int idx);
    return (idx >= 0) && ir_hist;
  endfunction

endmodule
